my_program_counter_16: RTL and testbench

//   16-bit program counter: the stage directly downstream of my_incrementer_16.

---
 rtl/my_pc_pkg.sv | 12 +
 rtl/my_incrementer_16.sv | 14 +
 rtl/my_program_counter_16.sv | 92 +++++++++
 tb/tb_my_program_counter_16.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/my_pc_pkg.sv
// Shared types and widths for the program-counter slice.
package my_pc_pkg;

   localparam int PC_WIDTH = 16;

   typedef enum logic [1:0] {
      PC_BOOT,
      PC_RUN,
      PC_HALTED
   } pc_state_t;

endpackage : my_pc_pkg

// File: rtl/my_incrementer_16.sv
// Combinational +1 on the fetch address, modulo 2^16 (carry-out dropped).
module my_incrementer_16
   import my_pc_pkg::*;
(
   output logic [PC_WIDTH-1:0] sum,
   input  logic [PC_WIDTH-1:0] x
);

   // Unsigned add of one; the natural truncation gives the FFFF -> 0000 wrap.
   always_comb begin
      sum = x + PC_WIDTH'(1);
   end

endmodule : my_incrementer_16

// File: rtl/my_program_counter_16.sv
// 16-bit program counter with boot/halt sequencing, a valid flag for the
// instruction ROM and a one-cycle wrap pulse.
module my_program_counter_16
   import my_pc_pkg::*;
#(
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 16'h0000
)(
   input  logic                clk,
   input  logic                reset,
   input  logic [PC_WIDTH-1:0] in,
   input  logic                load,
   input  logic                inc,
   input  logic                stall,
   input  logic                halt,
   output logic [PC_WIDTH-1:0] out,
   output logic                out_valid,
   output logic                wrapped
);

   pc_state_t           state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d, pc_plus1;
   logic                valid_q, valid_d;
   logic                wrapped_q, wrapped_d;

   my_incrementer_16 u_inc (pc_plus1, pc_q);

   // Next-state, next-address and flag selection; load outranks halt, halt
   // outranks stall, stall outranks inc.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a signal unassigned, which would otherwise infer a latch.
      state_d   = state_q;
      pc_d      = pc_q;
      valid_d   = valid_q;
      wrapped_d = 1'b0;
      unique case (state_q)
         PC_BOOT: begin
            state_d = PC_RUN;
            valid_d = 1'b1;
         end
         PC_RUN: begin
            if (load) begin
               pc_d    = in;
               valid_d = 1'b1;
            end else if (halt) begin
               state_d = PC_HALTED;
               valid_d = 1'b0;
            end else if (stall) begin
               pc_d = pc_q;
            end else if (inc) begin
               pc_d      = pc_plus1;
               wrapped_d = (pc_q == {PC_WIDTH{1'b1}});
            end
         end
         PC_HALTED: begin
            valid_d = 1'b0;
            if (load) begin
               pc_d    = in;
               state_d = PC_RUN;
               valid_d = 1'b1;
            end
         end
         default: begin
            state_d = PC_BOOT;
            pc_d    = RESET_VECTOR;
            valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers; synchronous reset has priority over all inputs.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      if (reset) begin
         state_q   <= PC_BOOT;
         pc_q      <= RESET_VECTOR;
         valid_q   <= 1'b0;
         wrapped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         valid_q   <= valid_d;
         wrapped_q <= wrapped_d;
      end
   end

   assign out       = pc_q;
   assign out_valid = valid_q;
   assign wrapped   = wrapped_q;

endmodule : my_program_counter_16

// File: tb/tb_my_program_counter_16.sv
// Scoreboard bench: the stimulus side runs an abstract model of the counter
// and queues the expected outputs; a monitor pops and compares each cycle.
module tb_my_program_counter_16;

   localparam logic [15:0] RV = 16'h0000;

   logic        clk = 1'b0;
   logic        reset, load, inc, stall, halt;
   logic [15:0] in, out;
   logic        out_valid, wrapped;

   typedef struct {
      logic [15:0] out;
      logic        valid;
      logic        wrapped;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model: an address as a plain integer plus two mode flags.
   int m_addr = 0;
   bit m_boot = 1'b1;
   bit m_halt = 1'b0;

   my_program_counter_16 #(.RESET_VECTOR(RV)) dut (
      .clk(clk), .reset(reset), .in(in), .load(load), .inc(inc),
      .stall(stall), .halt(halt), .out(out), .out_valid(out_valid),
      .wrapped(wrapped)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
   endtask

   // One cycle of stimulus: drive on the falling edge, advance the model,
   // queue what the DUT must show after the next rising edge.
   task automatic step(input bit r, input bit l, input logic [15:0] d,
                       input bit i, input bit s, input bit h);
      exp_t e;
      bit   w;
      @(negedge clk);
      reset = r; load = l; inc = i; stall = s; halt = h;
      in    = l ? d : 16'hxxxx;
      w = 1'b0;
      if (r) begin
         m_addr = RV; m_boot = 1'b1; m_halt = 1'b0;
      end else if (m_boot) begin
         m_boot = 1'b0;
      end else if (m_halt) begin
         if (l) begin m_addr = d; m_halt = 1'b0; end
      end else if (l) begin
         m_addr = d;
      end else if (h) begin
         m_halt = 1'b1;
      end else if (!s && i) begin
         w      = (m_addr == 65535);
         m_addr = (m_addr + 1) % 65536;
      end
      e.out     = m_addr[15:0];
      e.valid   = !m_boot && !m_halt;
      e.wrapped = w;
      sb_q.push_back(e);
   endtask

   // Monitor: sample 1 ns after each rising edge and compare against the queue.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("out",     out,               e.out);
            check("valid",   {15'b0, out_valid}, {15'b0, e.valid});
            check("wrapped", {15'b0, wrapped},   {15'b0, e.wrapped});
         end
      end
   end

   initial begin
      reset = 1'b1; load = 1'b0; inc = 1'b0; stall = 1'b0; halt = 1'b0; in = 16'h0000;

      // Boot sequence with inc held.
      step(1, 0, 0, 1, 0, 0);
      step(1, 0, 0, 1, 0, 0);
      repeat (5) step(0, 0, 0, 1, 0, 0);

      // Load beats stall and inc in the same cycle.
      step(0, 1, 16'h0005, 0, 0, 0);
      step(0, 1, 16'h0F0F, 1, 1, 0);
      step(0, 0, 0, 1, 0, 0);

      // Wrap from FFFF to 0000.
      step(0, 1, 16'hFFFE, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 16'h0000, 0, 0, 0);

      // Halt, ignored incs, resume with load.
      step(0, 1, 16'h0042, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      repeat (3) step(0, 0, 0, 1, 0, 0);
      step(0, 1, 16'h0100, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Reset in the middle of counting, then full reboot.
      step(0, 1, 16'h1234, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      step(1, 0, 0, 1, 0, 0);
      repeat (3) step(0, 0, 0, 1, 0, 0);

      // Stall holds the address with valid high.
      step(0, 1, 16'h0007, 0, 0, 0);
      repeat (4) step(0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 1, 0, 0);

      // Randomised traffic, biased toward the wrap boundary.
      for (int k = 0; k < 600; k++) begin
         logic [15:0] d;
         d = ($urandom % 4 == 0) ? (16'hFFFE + 16'($urandom % 2)) : 16'($urandom);
         step(($urandom % 50) == 0, ($urandom % 6) == 0, d,
              ($urandom % 4) != 0, ($urandom % 5) == 0, ($urandom % 12) == 0);
      end

      // Drain: every queued expectation must have been consumed.
      repeat (3) @(posedge clk);
      #2;
      n_checks++;
      if (sb_q.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d pending entries expected 0", sb_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_my_program_counter_16
